// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin, session-locked arbiter sharing one SRAM port
// between the packet writer (requester 0) and the header parser (requester 1).
// Accesses reach the SRAM one registered cycle after the strobe, and read data
// returns to the issuing requester exactly two cycles after the strobe.
module sram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_i,
  output logic [1:0]          gnt_o,
  input  logic [1:0]          ce_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [7:0]          sel_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rvalid_o,
  output logic                timeout_o,
  output logic                sram_ce_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [3:0]          sram_sel_o,
  output logic [DATA_W-1:0]   sram_data_o,
  input  logic [DATA_W-1:0]   sram_data_i
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  // Hold counter runs 0..MAX_HOLD-1; a disabled limit still needs one bit.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                timeout_q, timeout_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // Read-return pipeline: stage 1 marks a read on the SRAM bus, stage 2 is
  // the strobe presented to the requester. The owner tag travels with it so
  // reads outliving their session still return to the right requester.
  logic                rd1_valid;
  logic                rd1_owner;
  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata_q;

  // Owner's request fields.
  logic                own_req, own_ce, own_we, other_req, pick, access;
  logic [ADDR_W-1:0]   own_addr;
  logic [3:0]          own_sel;
  logic [DATA_W-1:0]   own_data;

  assign own_req   = req_i[owner_q];
  assign own_ce    = ce_i[owner_q];
  assign own_we    = we_i[owner_q];
  assign other_req = req_i[~owner_q];
  assign own_addr  = owner_q ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
  assign own_sel   = owner_q ? sel_i[4 +: 4]             : sel_i[0 +: 4];
  assign own_data  = owner_q ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];

  // First requesting index at or after the round-robin pointer.
  assign pick = req_i[rr_q] ? rr_q : ~rr_q;

  // An access is accepted only while the session is still requested.
  assign access = (state_q == OWN) && own_req && own_ce;

  // Next-state and next-output computation for the session FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    ce_d      = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          hold_d  = '0;
          state_d = OWN;
        end
      end

      OWN: begin
        if (!own_req) begin
          // Session ends; a strobe in this cycle is dropped.
          gnt_d   = 2'b00;
          state_d = TURN;
        end else begin
          addr_d = own_addr;
          if (own_ce) begin
            ce_d   = 1'b1;
            we_d   = own_we;
            sel_d  = own_sel;
            data_d = own_data;
          end
          // Saturate at the limit so a lone owner can hold indefinitely.
          if (MAX_HOLD == 0 || hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
          if (MAX_HOLD != 0 && hold_q == HOLD_LAST && other_req) begin
            gnt_d     = 2'b00;
            timeout_d = 1'b1;
            state_d   = TURN;
          end
        end
      end

      TURN: begin
        gnt_d   = 2'b00;
        rr_d    = ~owner_q;
        hold_d  = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Session state and registered SRAM command.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      hold_q    <= '0;
      gnt_q     <= 2'b00;
      timeout_q <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
    end
  end

  // Read-return pipeline with owner tag; reset discards reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_valid <= 1'b0;
      rd1_owner <= 1'b0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      rd1_valid <= access && !own_we;
      rd1_owner <= owner_q;
      rvalid_q  <= rd1_valid ? (rd1_owner ? 2'b10 : 2'b01) : 2'b00;
      if (rd1_valid) begin
        rdata_q <= sram_data_i;
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign timeout_o   = timeout_q;
  assign sram_ce_o   = ce_q;
  assign sram_we_o   = we_q;
  assign sram_addr_o = addr_q;
  assign sram_sel_o  = sel_q;
  assign sram_data_o = data_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;

endmodule
